// File: rtl/mux_5bits.sv
// Two-input destination-register mux (rt vs. rd) with an optional registered copy
// that honours pipeline stall (Enable=0) and flush.
module mux_5bits #(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Select,
  input  logic             Enable,
  input  logic             Flush,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] OutQ
);

  // Only a definite 1 picks B; an X/Z select falls back to A so Out never goes unknown.
  always_comb begin
    Out = A;
    if (Select === 1'b1) Out = B;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      OutQ <= RESET_VALUE;
    else if (Flush)  OutQ <= RESET_VALUE;
    else if (Enable) OutQ <= Out;
  end

endmodule

// File: tb/tb_mux_5bits.sv
// Directed bench for mux_5bits: combinational select, reset, stall, flush priority,
// asynchronous reset mid-cycle and unknown-select fallback.
module tb_mux_5bits;

  logic       Clk;
  logic       Rst_n;
  logic [4:0] A;
  logic [4:0] B;
  logic       Select;
  logic       Enable;
  logic       Flush;
  logic [4:0] Out;
  logic [4:0] OutQ;

  int errors = 0;
  int checks = 0;

  mux_5bits dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .A      (A),
    .B      (B),
    .Select (Select),
    .Enable (Enable),
    .Flush  (Flush),
    .Out    (Out),
    .OutQ   (OutQ)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] exp_x;

    // Combinational select while reset is held
    Rst_n  = 1'b0;
    Enable = 1'b1;
    Flush  = 1'b0;
    A      = 5'b01010;
    B      = 5'b11110;
    Select = 1'b0;
    #1;
    check("sel0_out", Out, 5'b01010);
    check("reset_outq", OutQ, 5'b00000);
    #10;
    Select = 1'b1;
    #1;
    check("sel1_out", Out, 5'b11110);

    // Clock toggling with Enable=1 under reset: OutQ stays cleared, Out still tracks
    @(negedge Clk);
    check("reset_hold1", OutQ, 5'b00000);
    B = 5'b00110;
    #1;
    check("reset_out_track", Out, 5'b00110);
    @(negedge Clk);
    check("reset_hold2", OutQ, 5'b00000);

    // Registered load, then stall
    Rst_n  = 1'b1;
    Select = 1'b1;
    B      = 5'b10101;
    Enable = 1'b1;
    @(negedge Clk);
    check("load_outq", OutQ, 5'b10101);
    Enable = 1'b0;
    B      = 5'b00011;
    @(negedge Clk);
    check("stall_outq", OutQ, 5'b10101);
    check("stall_out", Out, 5'b00011);

    // Flush beats Enable
    Enable = 1'b1;
    B      = 5'b11111;
    @(negedge Clk);
    check("load_ones", OutQ, 5'b11111);
    Flush = 1'b1;
    @(negedge Clk);
    check("flush_over_en", OutQ, 5'b00000);
    Enable = 1'b0;
    B      = 5'b01001;
    @(negedge Clk);
    check("flush_no_en", OutQ, 5'b00000);
    Flush = 1'b0;

    // Asynchronous reset between edges
    Enable = 1'b1;
    Select = 1'b0;
    A      = 5'b01100;
    @(negedge Clk);
    check("load_a", OutQ, 5'b01100);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_reset", OutQ, 5'b00000);
    check("async_out", Out, 5'b01100);
    @(negedge Clk);
    check("reset_drop_load", OutQ, 5'b00000);

    // First edge after release loads; stalled edge after release does not
    Rst_n  = 1'b1;
    Enable = 1'b0;
    @(negedge Clk);
    check("release_stall", OutQ, 5'b00000);
    Enable = 1'b1;
    A      = 5'b10010;
    @(negedge Clk);
    check("release_load", OutQ, 5'b10010);

    // A == B: Select irrelevant
    A      = 5'b10011;
    B      = 5'b10011;
    Select = 1'b0;
    #1;
    check("eq_sel0", Out, 5'b10011);
    Select = 1'b1;
    #1;
    check("eq_sel1", Out, 5'b10011);

    // Unknown select falls back to A (two-state simulators may resolve X to a value)
    A      = 5'b00111;
    B      = 5'b11000;
    Select = 1'bx;
    #1;
    exp_x = (Select === 1'b1) ? 5'b11000 : 5'b00111;
    check("sel_x", Out, exp_x);
    Select = 1'b0;
    @(negedge Clk);
    check("sel_x_load", OutQ, 5'b00111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
